// File: rtl/pll_reconf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reconf_pkg
// Description : Shared state encoding and default sizing for PLL reconfig
//               loader and the ROM output-delay stages.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_reconf_pkg;

    localparam int c_SCAN_BITS    = 144;
    localparam int c_ROM_LAT      = 2;
    localparam int c_DONE_TIMEOUT = 1023;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_LOADED    = 3'd3,
        ST_SHIFT     = 3'd4,
        ST_UPDATE    = 3'd5,
        ST_WAIT_DONE = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_scan_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pll_scan_shifter
// Description : Shadow scan register, scanclk divider and half-cycle counter
//               driving the PLL scan chain.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_scan_shifter
    import pll_reconf_pkg::*;
#(
    parameter int SCAN_BITS = c_SCAN_BITS
) (
    input  logic clock,
    input  logic reset,
    input  logic capture_ena,
    input  logic capture_bit,
    input  logic start,
    output logic done,
    output logic scanclk,
    output logic scanclkena,
    output logic scandata
);

    localparam int                  c_HALF_W    = $clog2(2 * SCAN_BITS);
    localparam logic [c_HALF_W-1:0] c_LAST_HALF = c_HALF_W'(2 * SCAN_BITS - 1);

    logic [SCAN_BITS-1:0] r_shadow;
    logic [c_HALF_W-1:0]  r_half;
    logic [c_HALF_W-2:0]  w_next_bit;

    // Only consulted while scanclk is high, i.e. r_half is odd.
    assign w_next_bit = r_half[c_HALF_W-1:1] + 1'b1;
    assign done       = scanclkena && (r_half == c_LAST_HALF);

    // First captured bit ends up in bit 0 after a full load, so it shifts out first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (capture_ena) begin
            r_shadow <= {capture_bit, r_shadow[SCAN_BITS-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_half     <= '0;
            scanclk    <= 1'b0;
            scanclkena <= 1'b0;
            scandata   <= 1'b0;
        end else if (start) begin
            r_half     <= '0;
            scanclk    <= 1'b0;
            scanclkena <= 1'b1;
            scandata   <= r_shadow[0];
        end else if (scanclkena) begin
            if (done) begin
                scanclk    <= 1'b0;
                scanclkena <= 1'b0;
            end else begin
                r_half  <= r_half + 1'b1;
                scanclk <= ~scanclk;
                // Data moves only on the falling scanclk edge.
                if (scanclk) begin
                    scandata <= r_shadow[w_next_bit];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_scan_loader.sv
`default_nettype none
// ============================================================================
// Module      : pll_scan_loader
// Description : Loads a PLL scan image from the reconfig ROM and shifts it
//               into the PLL scan chain followed by configupdate.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_scan_loader
    import pll_reconf_pkg::*;
#(
    parameter int SCAN_BITS    = c_SCAN_BITS,
    parameter int ADDR_W       = 8,
    parameter int ROM_LAT      = c_ROM_LAT,
    parameter int DONE_TIMEOUT = c_DONE_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trigger_read,
    input  logic              reconfig,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_read_ena,
    input  logic              rom_q,
    output logic              busy,
    output logic              loaded,
    output logic              scanclk,
    output logic              scanclkena,
    output logic              scandata,
    output logic              configupdate,
    input  logic              scandone,
    output logic              timeout_err
);

    localparam int                 c_CNT_MAX      = (DONE_TIMEOUT > ROM_LAT) ? DONE_TIMEOUT : ROM_LAT;
    localparam int                 c_CNT_W        = $clog2(c_CNT_MAX + 1);
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR    = ADDR_W'(SCAN_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST   = c_CNT_W'(ROM_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(DONE_TIMEOUT - 1);

    state_t               r_state;
    logic [ROM_LAT-1:0]   r_valid_pipe;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_scandone_d;
    logic                 w_start;
    logic                 w_shift_done;
    logic                 w_scandone_rise;

    // trigger_read has priority over reconfig when both arrive in LOADED.
    assign w_start         = (r_state == ST_LOADED) && reconfig && !trigger_read;
    assign w_scandone_rise = scandone && !r_scandone_d;

    pll_scan_shifter #(
        .SCAN_BITS (SCAN_BITS)
    ) u_shifter (
        .clock       (clock),
        .reset       (reset),
        .capture_ena (r_valid_pipe[ROM_LAT-1]),
        .capture_bit (rom_q),
        .start       (w_start),
        .done        (w_shift_done),
        .scanclk     (scanclk),
        .scanclkena  (scanclkena),
        .scandata    (scandata)
    );

    // Delays the read enable by the ROM latency so capture lines up with rom_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid_pipe <= '0;
            r_scandone_d <= 1'b0;
        end else begin
            r_valid_pipe[0] <= rom_read_ena;
            for (int k = 1; k < ROM_LAT; k++) begin
                r_valid_pipe[k] <= r_valid_pipe[k-1];
            end
            r_scandone_d <= scandone;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            rom_address  <= '0;
            rom_read_ena <= 1'b0;
            busy         <= 1'b0;
            loaded       <= 1'b0;
            configupdate <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            configupdate <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOADED: begin
                    if (trigger_read) begin
                        r_state      <= ST_READ;
                        rom_address  <= '0;
                        rom_read_ena <= 1'b1;
                        busy         <= 1'b1;
                        loaded       <= 1'b0;
                    end else if (w_start) begin
                        r_state <= ST_SHIFT;
                        busy    <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (rom_address == c_LAST_ADDR) begin
                        r_state      <= ST_DRAIN;
                        rom_read_ena <= 1'b0;
                        r_cnt        <= '0;
                    end else begin
                        rom_address <= rom_address + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == c_DRAIN_LAST) begin
                        r_state <= ST_LOADED;
                        loaded  <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_shift_done) begin
                        r_state      <= ST_UPDATE;
                        configupdate <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    // Counting from 1 makes the timeout land DONE_TIMEOUT clocks after configupdate.
                    r_state <= ST_WAIT_DONE;
                    r_cnt   <= c_CNT_W'(1);
                end
                ST_WAIT_DONE: begin
                    if (w_scandone_rise) begin
                        r_state <= ST_LOADED;
                        busy    <= 1'b0;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_state     <= ST_LOADED;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_scan_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_scan_loader
// Description : Directed self-checking bench for pll_scan_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_scan_loader;

    localparam int SCAN_BITS    = 144;
    localparam int ADDR_W       = 8;
    localparam int ROM_LAT      = 2;
    localparam int DONE_TIMEOUT = 1023;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              trigger_read = 1'b0;
    logic              reconfig = 1'b0;
    logic [ADDR_W-1:0] rom_address;
    logic              rom_read_ena;
    logic              rom_q;
    logic              busy;
    logic              loaded;
    logic              scanclk;
    logic              scanclkena;
    logic              scandata;
    logic              configupdate;
    logic              scandone = 1'b0;
    logic              timeout_err;

    logic              rom_mem [0:255];
    logic              rom_s1;
    logic              rom_s2;
    logic [15:0]       outs;

    int n_vec  = 0;
    int n_miss = 0;

    pll_scan_loader #(
        .SCAN_BITS    (SCAN_BITS),
        .ADDR_W       (ADDR_W),
        .ROM_LAT      (ROM_LAT),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .trigger_read (trigger_read),
        .reconfig     (reconfig),
        .rom_address  (rom_address),
        .rom_read_ena (rom_read_ena),
        .rom_q        (rom_q),
        .busy         (busy),
        .loaded       (loaded),
        .scanclk      (scanclk),
        .scanclkena   (scanclkena),
        .scandata     (scandata),
        .configupdate (configupdate),
        .scandone     (scandone),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    // Two-stage ROM: data for the address seen in cycle c is on rom_q in cycle c+2.
    always @(posedge clock) begin
        rom_s1 <= rom_mem[rom_address];
        rom_s2 <= rom_s1;
    end
    assign rom_q = rom_s2;

    assign outs = {rom_address, rom_read_ena, busy, loaded, scanclk,
                   scanclkena, scandata, configupdate, timeout_err};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (outs !== 16'h0000) begin
            n_miss++;
            $display("FAIL reset_outputs: got %h required 0000", outs);
        end
        reset = 1'b0;
        tick();
        tick();
        n_vec++;
        if (outs !== 16'h0000) begin
            n_miss++;
            $display("FAIL idle_outputs: got %h required 0000", outs);
        end
    endtask

    task automatic test_reconfig_idle();
        int active = 0;
        reconfig = 1'b1;
        tick();
        reconfig = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (scanclkena !== 1'b0 || busy !== 1'b0) active++;
            tick();
        end
        n_vec++;
        if (active !== 0) begin
            n_miss++;
            $display("FAIL reconfig_idle: %0d active cycles, required 0", active);
        end
    endtask

    task automatic test_load(input bit ones, input bit poke, input bit with_reconfig);
        int first_bad = -1;
        logic [ADDR_W-1:0] bad_addr = '0;
        for (int a = 0; a < 256; a++) rom_mem[a] = ones ? 1'b1 : a[0];
        trigger_read = 1'b1;
        reconfig     = with_reconfig;
        tick();
        trigger_read = 1'b0;
        reconfig     = 1'b0;
        for (int k = 0; k < SCAN_BITS; k++) begin
            if (first_bad < 0 && (rom_read_ena !== 1'b1 || rom_address !== ADDR_W'(k) ||
                                  loaded !== 1'b0 || busy !== 1'b1 || scanclkena !== 1'b0)) begin
                first_bad = k;
                bad_addr  = rom_address;
            end
            if (poke && k == 50) trigger_read = 1'b1;
            tick();
            trigger_read = 1'b0;
        end
        n_vec++;
        if (first_bad >= 0) begin
            n_miss++;
            $display("FAIL load_walk: step %0d got addr %0d, required addr %0d with ena=1 busy=1 loaded=0",
                     first_bad, bad_addr, first_bad);
        end
        for (int d = 0; d < ROM_LAT; d++) begin
            n_vec++;
            if ({rom_read_ena, busy, loaded} !== 3'b010 || rom_address !== ADDR_W'(SCAN_BITS - 1)) begin
                n_miss++;
                $display("FAIL load_drain%0d: ena/busy/loaded=%b addr=%0d, required 010 addr=%0d",
                         d, {rom_read_ena, busy, loaded}, rom_address, SCAN_BITS - 1);
            end
            tick();
        end
        n_vec++;
        if ({busy, loaded} !== 2'b01) begin
            n_miss++;
            $display("FAIL load_done: busy/loaded=%b required 01", {busy, loaded});
        end
    endtask

    task automatic test_shift(input bit ones, input int done_delay, input bit exp_terr);
        int   first_ctl = -1;
        int   first_dat = -1;
        int   first_hold = -1;
        int   rises = 0;
        int   idx;
        logic prev_clk = 1'b0;
        logic prev_d = 1'b0;
        logic exp_clk;
        logic exp_d;
        logic bad_d = 1'b0;
        reconfig = 1'b1;
        tick();
        reconfig = 1'b0;
        for (int j = 1; j <= 2 * SCAN_BITS; j++) begin
            exp_clk = (j % 2 == 0);
            if (first_ctl < 0 && (scanclkena !== 1'b1 || scanclk !== exp_clk ||
                                  configupdate !== 1'b0 || busy !== 1'b1)) first_ctl = j;
            if (scanclkena === 1'b1 && scanclk === 1'b1 && prev_clk === 1'b0) begin
                idx   = rises;
                rises++;
                exp_d = ones ? 1'b1 : idx[0];
                if (first_dat < 0 && scandata !== exp_d) begin
                    first_dat = idx;
                    bad_d     = scandata;
                end
                if (first_hold < 0 && scandata !== prev_d) first_hold = j;
            end
            prev_clk = scanclk;
            prev_d   = scandata;
            tick();
        end
        n_vec++;
        if (first_ctl >= 0) begin
            n_miss++;
            $display("FAIL shift_ctrl: first bad cycle %0d after reconfig, required ena=1 clk=%0d cu=0 busy=1",
                     first_ctl, (first_ctl % 2 == 0));
        end
        n_vec++;
        if (first_dat >= 0) begin
            n_miss++;
            $display("FAIL shift_data: bit %0d got %b required %b",
                     first_dat, bad_d, ones ? 1'b1 : first_dat[0]);
        end
        n_vec++;
        if (first_hold >= 0) begin
            n_miss++;
            $display("FAIL shift_hold: scandata changed at rising scanclk, cycle %0d, required stable", first_hold);
        end
        n_vec++;
        if (rises !== SCAN_BITS) begin
            n_miss++;
            $display("FAIL shift_rises: got %0d required %0d", rises, SCAN_BITS);
        end
        n_vec++;
        if ({scanclkena, scanclk, configupdate, busy} !== 4'b0011) begin
            n_miss++;
            $display("FAIL update_pulse: ena/clk/cu/busy=%b required 0011",
                     {scanclkena, scanclk, configupdate, busy});
        end
        tick();
        n_vec++;
        if ({configupdate, busy} !== 2'b01) begin
            n_miss++;
            $display("FAIL update_end: cu/busy=%b required 01", {configupdate, busy});
        end
        if (done_delay > 0) begin
            repeat (done_delay - 1) tick();
            n_vec++;
            if (busy !== 1'b1) begin
                n_miss++;
                $display("FAIL wait_done_busy: busy=%b required 1", busy);
            end
            scandone = 1'b1;
            tick();
            scandone = 1'b0;
            n_vec++;
            if ({busy, loaded, timeout_err} !== {2'b01, exp_terr}) begin
                n_miss++;
                $display("FAIL scandone_return: busy/loaded/terr=%b required 01%b",
                         {busy, loaded, timeout_err}, exp_terr);
            end
        end else begin
            repeat (DONE_TIMEOUT - 2) tick();
            n_vec++;
            if ({busy, timeout_err} !== 2'b10) begin
                n_miss++;
                $display("FAIL timeout_early: busy/terr=%b required 10", {busy, timeout_err});
            end
            tick();
            n_vec++;
            if ({busy, loaded, timeout_err} !== 3'b011) begin
                n_miss++;
                $display("FAIL timeout_set: busy/loaded/terr=%b required 011",
                         {busy, loaded, timeout_err});
            end
        end
    endtask

    task automatic test_timeout();
        test_shift(1'b0, -1, 1'b1);
    endtask

    task automatic test_simultaneous();
        test_load(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        test_shift(1'b1, 20, 1'b1);
    endtask

    task automatic test_reset_mid_shift();
        int active = 0;
        reconfig = 1'b1;
        tick();
        reconfig = 1'b0;
        repeat (140) tick();
        n_vec++;
        if (scanclkena !== 1'b1) begin
            n_miss++;
            $display("FAIL mid_shift_active: scanclkena=%b required 1", scanclkena);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (outs !== 16'h0000) begin
            n_miss++;
            $display("FAIL reset_async: got %h required 0000", outs);
        end
        tick();
        reset = 1'b0;
        tick();
        reconfig = 1'b1;
        tick();
        reconfig = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (scanclkena !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0) active++;
            tick();
        end
        n_vec++;
        if (active !== 0) begin
            n_miss++;
            $display("FAIL reconfig_after_reset: %0d active cycles, required 0", active);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 256; a++) rom_mem[a] = 1'b0;
        test_reset();
        test_reconfig_idle();
        test_load(1'b0, 1'b1, 1'b0);
        test_shift(1'b0, 20, 1'b0);
        test_timeout();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
